// File: rtl/sdram_aref_sched_if.sv
// sdram_aref_sched_if -- auto-refresh scheduler <-> arbiter/command bus.
//   init_end      : initialisation complete (level, driven by the slave side)
//   aref_en       : arbiter grant (driven by the slave side)
//   aref_req      : refresh request to the arbiter
//   aref_end      : one-cycle pulse at the end of the refresh sequence
//   aref_cmd      : {cs_n, ras_n, cas_n, we_n}
//   aref_ba       : bank address
//   aref_addr     : address bus
//   aref_miss_cnt : expiries seen while a request was already pending
//                   (SDRAM_AREF_STAT_EN only)
//   aref_busy     : refresh sequence in progress (SDRAM_AREF_STAT_EN only)
// Optional feature macro: SDRAM_AREF_STAT_EN.
interface sdram_aref_sched_if;
    logic        init_end;
    logic        aref_en;
    logic        aref_req;
    logic        aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [10:0] aref_addr;
`ifdef SDRAM_AREF_STAT_EN
    logic [7:0]  aref_miss_cnt;
    logic        aref_busy;

    modport master (
        input  init_end, aref_en,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output aref_miss_cnt, aref_busy
    );
    modport slave (
        output init_end, aref_en,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  aref_miss_cnt, aref_busy
    );
`else
    modport master (
        input  init_end, aref_en,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr
    );
    modport slave (
        output init_end, aref_en,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr
    );
`endif
endinterface

// File: rtl/sdram_aref_sched.sv
// sdram_aref_sched -- SDRAM auto-refresh scheduler and command sequencer.
// Times the refresh interval once initialisation is complete, requests the
// bus from the arbiter and, once granted, issues PRECHARGE-ALL followed by
// AREF_NUM AUTO-REFRESH commands, then pulses aref_end.
// Ports:
//   sys_clk : system clock, rising edge
//   sys_rst : asynchronous active-high reset
//   bus     : sdram_aref_sched_if.master (init_end/aref_en in, request,
//             end pulse, command/bank/address out)
// Optional feature macro: SDRAM_AREF_STAT_EN (miss counter + busy flag).
module sdram_aref_sched #(
    parameter int unsigned REF_CNT_MAX = 750,
    parameter int unsigned TRP_CLK     = 2,
    parameter int unsigned TRC_CLK     = 7,
    parameter int unsigned AREF_NUM    = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    sdram_aref_sched_if.master bus
);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PCHA = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    localparam int unsigned CNT_W    = $clog2(REF_CNT_MAX);
    localparam int unsigned WAIT_MAX = (TRP_CLK > TRC_CLK) ? TRP_CLK : TRC_CLK;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int unsigned NUM_W    = 4;

    typedef enum logic [2:0] {IDLE, PCHA, TRP, AREF, TRF, END} state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    ref_cnt, ref_cnt_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [NUM_W-1:0]    aref_num;
    logic                expire;
    logic                aref_req;

    // Interval counter: free-running while init_end is high.
    always_comb begin
        ref_cnt_next = '0;
        if (bus.init_end && ref_cnt != CNT_W'(REF_CNT_MAX - 1))
            ref_cnt_next = ref_cnt + CNT_W'(1);
    end

    // Expiry is the edge on which the counter reaches its terminal value.
    assign expire = bus.init_end && (ref_cnt_next == CNT_W'(REF_CNT_MAX - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            ref_cnt <= '0;
        else
            ref_cnt <= ref_cnt_next;
    end

    // Grant clears the request even if an expiry lands on the same edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            aref_req <= 1'b0;
        else if (bus.aref_en)
            aref_req <= 1'b0;
        else if (expire)
            aref_req <= 1'b1;
    end

    assign bus.aref_req = aref_req;

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.aref_en && bus.init_end) state_next = PCHA;
            PCHA: state_next = TRP;
            TRP:  if (wait_cnt == WAIT_W'(TRP_CLK - 1)) state_next = AREF;
            AREF: state_next = TRF;
            TRF:  if (wait_cnt == WAIT_W'(TRC_CLK - 1))
                      state_next = (aref_num < NUM_W'(AREF_NUM)) ? AREF : END;
            END:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Wait counter restarts on every state entry.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            wait_cnt <= '0;
        else if (state_next != state)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    // AUTO-REFRESH commands issued in the current sequence.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            aref_num <= '0;
        else if (state == AREF)
            aref_num <= aref_num + NUM_W'(1);
        else if (state == END)
            aref_num <= '0;
    end

    // Moore outputs. Bank and address sit at all-ones throughout, which also
    // satisfies the all-banks bit (addr[10]) during PRECHARGE.
    always_comb begin
        bus.aref_cmd  = CMD_NOP;
        bus.aref_ba   = '1;
        bus.aref_addr = '1;
        bus.aref_end  = 1'b0;
        case (state)
            PCHA: begin
                bus.aref_cmd      = CMD_PCHA;
                bus.aref_addr[10] = 1'b1;
            end
            AREF: bus.aref_cmd = CMD_AREF;
            END:  bus.aref_end = 1'b1;
            default: ;
        endcase
    end

`ifdef SDRAM_AREF_STAT_EN
    logic [7:0] miss_cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            miss_cnt <= '0;
        else if (expire && aref_req && miss_cnt != 8'hff)
            miss_cnt <= miss_cnt + 8'd1;
    end

    assign bus.aref_miss_cnt = miss_cnt;
    assign bus.aref_busy     = (state != IDLE);
`endif

endmodule

// File: tb/tb_sdram_aref_sched.sv
module tb_sdram_aref_sched;

    localparam int unsigned P_REF = 750;
    localparam int unsigned P_TRP = 2;
    localparam int unsigned P_TRC = 7;
    localparam int unsigned P_NUM = 2;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AUTO = 4'b0001;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sdram_aref_sched_if ifc ();

    sdram_aref_sched #(
        .REF_CNT_MAX (P_REF),
        .TRP_CLK     (P_TRP),
        .TRC_CLK     (P_TRC),
        .AREF_NUM    (P_NUM)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (ifc.master)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Expected per-cycle {aref_end, aref_cmd} of one refresh sequence.
    logic [4:0] seq[$];
    int seq_len;

    initial begin
        seq.push_back({1'b0, PRE});
        for (int i = 0; i < int'(P_TRP); i++) seq.push_back({1'b0, NOP});
        for (int n = 0; n < int'(P_NUM); n++) begin
            seq.push_back({1'b0, AUTO});
            for (int i = 0; i < int'(P_TRC); i++) seq.push_back({1'b0, NOP});
        end
        seq.push_back({1'b1, NOP});
        seq_len = seq.size();
    end

    // Reference model: request timing from elapsed enabled cycles, sequence
    // occupancy as a countdown of the known sequence length.
    int mc   = 0;
    bit mreq = 1'b0;
    int mrem = 0;
    int mmiss = 0;
    int cyc  = 0;
    bit mexp;
    int mq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mc = 0; mreq = 1'b0; mrem = 0; mmiss = 0;
            mq.delete();
        end else begin
            cyc++;
            mexp = 1'b0;
            if (!ifc.init_end) mc = 0;
            else begin
                mc = (mc + 1) % int'(P_REF);
                mexp = (mc == int'(P_REF) - 1);
            end
            if (mexp && mreq && mmiss < 255) mmiss++;
            if (ifc.aref_en) mreq = 1'b0;
            else if (mexp) mreq = 1'b1;
            if (mrem > 0) mrem--;
            else if (ifc.aref_en && ifc.init_end) begin
                mrem = seq_len;
                mq.push_back(cyc);
            end
        end
    end

    // Monitor: a PRECHARGE from the DUT opens a sequence, matched against
    // the oldest predicted grant.
    int idx = -1;
    int start;

    always @(negedge clk) begin
        if (rst) idx = -1;
        else begin
            chk("aref_req", ifc.aref_req, mreq);
            chk("aref_ba", ifc.aref_ba, 2'b11);
            chk("aref_addr", ifc.aref_addr, 11'h7ff);
            if (idx < 0 && ifc.aref_cmd == PRE) begin
                chk("seq_expected", mq.size() != 0, 1);
                if (mq.size() != 0) begin
                    start = mq.pop_front();
                    chk("seq_start_cycle", cyc, start);
                end
                idx = 0;
            end
            if (idx >= 0) begin
                chk("seq_step", {ifc.aref_end, ifc.aref_cmd}, seq[idx]);
                idx++;
                if (idx == seq_len) idx = -1;
            end else
                chk("idle_cmd", {ifc.aref_end, ifc.aref_cmd}, {1'b0, NOP});
`ifdef SDRAM_AREF_STAT_EN
            chk("miss_cnt", ifc.aref_miss_cnt, mmiss);
            chk("busy", ifc.aref_busy, mrem > 0);
`endif
        end
    end

    // Arbiter: grants after a random delay, holds until the edge after
    // aref_end (or gives up if no sequence starts).
    bit withhold = 1'b0;
    bit drop_next = 1'b0;
    int hold_cnt = 0;
    int delay = 1;

    always @(negedge clk) begin
        if (rst) begin
            ifc.aref_en = 1'b0; drop_next = 1'b0; hold_cnt = 0;
        end else if (ifc.aref_en) begin
            hold_cnt++;
            if (drop_next) begin
                ifc.aref_en = 1'b0; drop_next = 1'b0;
            end else if (ifc.aref_end)
                drop_next = 1'b1;
            else if (hold_cnt > 40)
                ifc.aref_en = 1'b0;
        end else if (ifc.aref_req && !withhold) begin
            if (delay == 0) begin
                ifc.aref_en = 1'b1;
                hold_cnt = 0;
                delay = $urandom_range(0, 4);
            end else
                delay--;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, ifc.aref_req, 1'b0);
        chk({tag, "_end"}, ifc.aref_end, 1'b0);
        chk({tag, "_cmd"}, ifc.aref_cmd, NOP);
        chk({tag, "_ba"}, ifc.aref_ba, 2'b11);
        chk({tag, "_addr"}, ifc.aref_addr, 11'h7ff);
    endtask

    task automatic wait_req(input int limit, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ifc.aref_req && waited < limit);
        chk("wait_req_timeout", ifc.aref_req, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n;
    int gap;

    initial begin
        ifc.init_end = 1'b0;
        ifc.aref_en  = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 chk_reset_vals("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ifc.init_end = 1'b1;

        // First request 749 edges after enabling; then prompt grants.
        wait_req(2000, n);
        chk("first_req_latency", n, P_REF - 1);
        repeat (3 * P_REF) @(negedge clk);

        // Withheld grant: request stays pending across two more expiries.
        withhold = 1'b1;
        wait_req(2000, n);
        repeat (1600) @(negedge clk);
        chk("withheld_req_high", ifc.aref_req, 1'b1);
`ifdef SDRAM_AREF_STAT_EN
        chk("withheld_miss_cnt", ifc.aref_miss_cnt, 8'd2);
`endif
        withhold = 1'b0;
        repeat (100) @(negedge clk);

        // Interval counter held while init_end is low.
        ifc.init_end = 1'b0;
        repeat (2000) @(negedge clk);
        ifc.init_end = 1'b1;

        // Reset in TRF after the first AUTO_REF of a sequence.
        n = 0;
        while (ifc.aref_cmd != AUTO && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("found_auto_ref", ifc.aref_cmd, AUTO);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_req(2000, n);
        chk("req_after_reset", n, P_REF - 1);

        // Randomised run with sporadic init_end drops.
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (gap > 0) begin
                gap--;
                if (gap == 0) ifc.init_end = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                ifc.init_end = 1'b0;
                gap = $urandom_range(1, 50);
            end
        end
        ifc.init_end = 1'b1;
        withhold = 1'b1;
        repeat (60) @(negedge clk);
        chk("no_pending_seq", mq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
